// File: rtl/decoder.sv
// Instruction decoder: splits a 16-bit program word into opcode/param fields and
// produces registered register-file, ALU-mux, status and program-counter controls.
module decoder #(
  parameter int DataWidth         = 8,
  parameter int SEL_WIDTH         = 2,
  parameter int PROGRAM_DataWidth = 16,
  parameter int NumOpCodeBits     = 5,
  parameter int ParamBits         = 8,
  parameter int NumStatusBits     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PROGRAM_DataWidth-1:0] instruction,
  input  logic [NumStatusBits-1:0]     status,
  output logic [NumOpCodeBits-1:0]     opcode,
  output logic [ParamBits-1:0]         param,
  output logic [DataWidth-1:0]         literal_adr,
  output logic [SEL_WIDTH-1:0]         rd_sel1,
  output logic [SEL_WIDTH-1:0]         rd_sel2,
  output logic                         rd_en1,
  output logic                         rd_en2,
  output logic                         wr_en,
  output logic [SEL_WIDTH-1:0]         wr_sel,
  output logic                         sel_reg_in_alu_decoder,
  output logic                         cnt_wr_en,
  output logic                         add_offset,
  output logic                         stat_wr_en,
  output logic                         stat_reg_in_alu_decoder,
  output logic [NumStatusBits-1:0]     status_out
);

  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_ADD  = 5'h01;
  localparam logic [4:0] OP_SUB  = 5'h02;
  localparam logic [4:0] OP_AND  = 5'h03;
  localparam logic [4:0] OP_OR   = 5'h04;
  localparam logic [4:0] OP_NOT  = 5'h05;
  localparam logic [4:0] OP_XOR  = 5'h06;
  localparam logic [4:0] OP_SHL  = 5'h07;
  localparam logic [4:0] OP_SHR  = 5'h08;
  localparam logic [4:0] OP_VAL  = 5'h09;
  localparam logic [4:0] OP_GOTO = 5'h10;
  localparam logic [4:0] OP_IFZ  = 5'h11;
  localparam logic [4:0] OP_IFNZ = 5'h12;
  localparam logic [4:0] OP_IFEQ = 5'h13;
  localparam logic [4:0] OP_IFST = 5'h14;
  localparam logic [4:0] OP_IFGT = 5'h15;

  localparam int FlagC = 0;
  localparam int FlagZ = 2;

  logic [NumOpCodeBits-1:0] op_w;
  logic [SEL_WIDTH-1:0]     op1_w;
  logic [SEL_WIDTH-1:0]     op2_w;
  logic                     flag_c_w;
  logic                     flag_z_w;

  assign op_w     = instruction[15:11];
  assign op1_w    = instruction[9:8];
  assign op2_w    = instruction[4:3];
  assign flag_c_w = status[FlagC];
  assign flag_z_w = status[FlagZ];

  // Instruction class flags; each class shares one control pattern.
  logic is_alu2_w;
  logic is_not_w;
  logic is_shift_w;
  logic is_val_w;
  logic is_goto_w;
  logic is_cond_w;
  logic cond_taken_w;

  always_comb begin
    is_alu2_w    = 1'b0;
    is_not_w     = 1'b0;
    is_shift_w   = 1'b0;
    is_val_w     = 1'b0;
    is_goto_w    = 1'b0;
    is_cond_w    = 1'b0;
    cond_taken_w = 1'b0;
    case (op_w)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: is_alu2_w  = 1'b1;
      OP_NOT:                                is_not_w   = 1'b1;
      OP_SHL, OP_SHR:                        is_shift_w = 1'b1;
      OP_VAL:                                is_val_w   = 1'b1;
      OP_GOTO:                               is_goto_w  = 1'b1;
      OP_IFZ: begin
        is_cond_w    = 1'b1;
        cond_taken_w = flag_z_w;
      end
      OP_IFNZ: begin
        is_cond_w    = 1'b1;
        cond_taken_w = ~flag_z_w;
      end
      OP_IFEQ: begin
        is_cond_w    = 1'b1;
        cond_taken_w = flag_z_w;
      end
      OP_IFST: begin
        is_cond_w    = 1'b1;
        cond_taken_w = flag_c_w;
      end
      OP_IFGT: begin
        is_cond_w    = 1'b1;
        cond_taken_w = ~flag_z_w & ~flag_c_w;
      end
      default: ;
    endcase
  end

  logic [NumOpCodeBits-1:0] opcode_d,      opcode_q;
  logic [ParamBits-1:0]     param_d,       param_q;
  logic [DataWidth-1:0]     literal_adr_d, literal_adr_q;
  logic [SEL_WIDTH-1:0]     rd_sel1_d,     rd_sel1_q;
  logic [SEL_WIDTH-1:0]     rd_sel2_d,     rd_sel2_q;
  logic                     rd_en1_d,      rd_en1_q;
  logic                     rd_en2_d,      rd_en2_q;
  logic                     wr_en_d,       wr_en_q;
  logic [SEL_WIDTH-1:0]     wr_sel_d,      wr_sel_q;
  logic                     sel_alu_d,     sel_alu_q;
  logic                     cnt_wr_en_d,   cnt_wr_en_q;
  logic                     add_offset_d,  add_offset_q;
  logic                     stat_wr_en_d,  stat_wr_en_q;

  always_comb begin
    opcode_d      = op_w;
    param_d       = instruction[ParamBits-1:0];
    literal_adr_d = instruction[DataWidth-1:0];
    rd_sel1_d     = '0;
    rd_sel2_d     = '0;
    rd_en1_d      = 1'b0;
    rd_en2_d      = 1'b0;
    wr_en_d       = 1'b0;
    wr_sel_d      = '0;
    sel_alu_d     = 1'b0;
    cnt_wr_en_d   = 1'b0;
    add_offset_d  = 1'b0;
    stat_wr_en_d  = 1'b0;

    // Every ALU-producing instruction writes back to OP1 and updates flags.
    if (is_alu2_w || is_not_w || is_shift_w) begin
      sel_alu_d    = 1'b1;
      wr_en_d      = 1'b1;
      wr_sel_d     = op1_w;
      stat_wr_en_d = 1'b1;
    end
    if (is_alu2_w || is_shift_w) begin
      rd_sel1_d = op1_w;
      rd_en1_d  = 1'b1;
    end
    if (is_alu2_w || is_not_w) begin
      rd_sel2_d = op2_w;
      rd_en2_d  = 1'b1;
    end
    if (is_val_w) begin
      wr_en_d  = 1'b1;
      wr_sel_d = op1_w;
    end
    if (is_goto_w) begin
      cnt_wr_en_d = 1'b1;
    end
    if (is_cond_w && cond_taken_w) begin
      cnt_wr_en_d  = 1'b1;
      add_offset_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opcode_q      <= '0;
      param_q       <= '0;
      literal_adr_q <= '0;
      rd_sel1_q     <= '0;
      rd_sel2_q     <= '0;
      rd_en1_q      <= 1'b0;
      rd_en2_q      <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_sel_q      <= '0;
      sel_alu_q     <= 1'b0;
      cnt_wr_en_q   <= 1'b0;
      add_offset_q  <= 1'b0;
      stat_wr_en_q  <= 1'b0;
    end else begin
      opcode_q      <= opcode_d;
      param_q       <= param_d;
      literal_adr_q <= literal_adr_d;
      rd_sel1_q     <= rd_sel1_d;
      rd_sel2_q     <= rd_sel2_d;
      rd_en1_q      <= rd_en1_d;
      rd_en2_q      <= rd_en2_d;
      wr_en_q       <= wr_en_d;
      wr_sel_q      <= wr_sel_d;
      sel_alu_q     <= sel_alu_d;
      cnt_wr_en_q   <= cnt_wr_en_d;
      add_offset_q  <= add_offset_d;
      stat_wr_en_q  <= stat_wr_en_d;
    end
  end

  assign opcode                  = opcode_q;
  assign param                   = param_q;
  assign literal_adr             = literal_adr_q;
  assign rd_sel1                 = rd_sel1_q;
  assign rd_sel2                 = rd_sel2_q;
  assign rd_en1                  = rd_en1_q;
  assign rd_en2                  = rd_en2_q;
  assign wr_en                   = wr_en_q;
  assign wr_sel                  = wr_sel_q;
  assign sel_reg_in_alu_decoder  = sel_alu_q;
  assign cnt_wr_en               = cnt_wr_en_q;
  assign add_offset              = add_offset_q;
  assign stat_wr_en              = stat_wr_en_q;
  // The decoder never sources flags itself; the status mux always selects the ALU.
  assign stat_reg_in_alu_decoder = 1'b1;
  assign status_out              = '0;

endmodule

// File: tb/tb_decoder.sv
// Bench for decoder: directed vectors plus randomized instructions checked
// against a rule-level reference model of the instruction set.
module tb_decoder;

  typedef struct packed {
    logic [4:0] opcode;
    logic [7:0] param;
    logic [7:0] literal_adr;
    logic [1:0] rd_sel1;
    logic [1:0] rd_sel2;
    logic       rd_en1;
    logic       rd_en2;
    logic       wr_en;
    logic [1:0] wr_sel;
    logic       sel_alu;
    logic       cnt_wr_en;
    logic       add_offset;
    logic       stat_wr_en;
    logic       stat_in_alu;
    logic [3:0] status_out;
  } out_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] instruction = '0;
  logic [3:0]  status = '0;
  logic [4:0]  opcode;
  logic [7:0]  param, literal_adr;
  logic [1:0]  rd_sel1, rd_sel2, wr_sel;
  logic        rd_en1, rd_en2, wr_en, sel_reg_in_alu_decoder;
  logic        cnt_wr_en, add_offset, stat_wr_en, stat_reg_in_alu_decoder;
  logic [3:0]  status_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decoder dut (
    .clk(clk), .rst(rst), .instruction(instruction), .status(status),
    .opcode(opcode), .param(param), .literal_adr(literal_adr),
    .rd_sel1(rd_sel1), .rd_sel2(rd_sel2), .rd_en1(rd_en1), .rd_en2(rd_en2),
    .wr_en(wr_en), .wr_sel(wr_sel), .sel_reg_in_alu_decoder(sel_reg_in_alu_decoder),
    .cnt_wr_en(cnt_wr_en), .add_offset(add_offset), .stat_wr_en(stat_wr_en),
    .stat_reg_in_alu_decoder(stat_reg_in_alu_decoder), .status_out(status_out)
  );

  function automatic out_t observed();
    out_t o;
    o = {opcode, param, literal_adr, rd_sel1, rd_sel2, rd_en1, rd_en2, wr_en,
         wr_sel, sel_reg_in_alu_decoder, cnt_wr_en, add_offset, stat_wr_en,
         stat_reg_in_alu_decoder, status_out};
    return o;
  endfunction

  function automatic out_t reset_model();
    out_t e;
    e = '0;
    e.stat_in_alu = 1'b1;
    return e;
  endfunction

  // Reference: instruction-set rules, one opcode at a time.
  function automatic out_t model(input logic [15:0] ins, input logic [3:0] st);
    out_t e;
    int   op;
    logic z, c, jump;
    op = int'(ins[15:11]);
    z  = st[2];
    c  = st[0];
    e = reset_model();
    e.opcode      = ins[15:11];
    e.param       = ins[7:0];
    e.literal_adr = ins[7:0];
    jump = 1'b0;
    if (op == 1 || op == 2 || op == 3 || op == 4 || op == 6) begin
      e.rd_sel1 = ins[9:8]; e.rd_sel2 = ins[4:3];
      e.rd_en1 = 1; e.rd_en2 = 1; e.sel_alu = 1;
      e.wr_en = 1; e.wr_sel = ins[9:8]; e.stat_wr_en = 1;
    end else if (op == 5) begin
      e.rd_sel2 = ins[4:3]; e.rd_en2 = 1; e.sel_alu = 1;
      e.wr_en = 1; e.wr_sel = ins[9:8]; e.stat_wr_en = 1;
    end else if (op == 7 || op == 8) begin
      e.rd_sel1 = ins[9:8]; e.rd_en1 = 1; e.sel_alu = 1;
      e.wr_en = 1; e.wr_sel = ins[9:8]; e.stat_wr_en = 1;
    end else if (op == 9) begin
      e.wr_en = 1; e.wr_sel = ins[9:8];
    end else if (op == 16) begin
      e.cnt_wr_en = 1;
    end else if (op >= 17 && op <= 21) begin
      case (op)
        17: jump = z;
        18: jump = !z;
        19: jump = z;
        20: jump = c;
        default: jump = !z && !c;
      endcase
      e.cnt_wr_en  = jump;
      e.add_offset = jump;
    end
    return e;
  endfunction

  function automatic logic [15:0] mk(input int op, input int op1, input int op2, input int val);
    logic [15:0] w;
    w = '0;
    w[15:11] = op[4:0];
    w[7:0]   = val[7:0];
    w[9:8]   = op1[1:0];
    w[4:3]   = op2[1:0];
    return w;
  endfunction

  // Present inputs away from the edge, let one rising edge capture them, sample after it.
  task automatic drive(input logic r, input logic [15:0] ins, input logic [3:0] st);
    @(negedge clk);
    rst = r; instruction = ins; status = st;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    out_t exp_o, got;
    drive(1'b1, mk(1, 3, 3, 8'hFF), 4'hF);
    exp_o = reset_model(); got = observed();
    checks++;
    if (got !== exp_o) begin
      errors++;
      $display("FAIL reset: got %h expected %h", got, exp_o);
    end
    $display("reset: ins=%h got=%h", instruction, got);
  endtask

  task automatic test_directed();
    logic [15:0] ins_tab [12];
    logic [3:0]  st_tab  [12];
    out_t exp_o, got;
    ins_tab[0]  = mk(1, 1, 2, 0);      st_tab[0]  = 4'h0;  // ADD
    ins_tab[1]  = mk(5, 2, 0, 0);      st_tab[1]  = 4'h0;  // NOT
    ins_tab[2]  = mk(7, 1, 0, 5);      st_tab[2]  = 4'h0;  // SHL
    ins_tab[3]  = mk(9, 3, 0, 'hA5);   st_tab[3]  = 4'h0;  // VAL
    ins_tab[4]  = mk(16, 0, 0, 'h3F);  st_tab[4]  = 4'hF;  // GOTO
    ins_tab[5]  = mk(17, 0, 0, 8);     st_tab[5]  = 4'h0;  // IFZ not taken
    ins_tab[6]  = mk(17, 0, 0, 9);     st_tab[6]  = 4'h4;  // IFZ taken
    ins_tab[7]  = mk(18, 0, 0, 9);     st_tab[7]  = 4'h4;  // IFNZ not taken
    ins_tab[8]  = mk(18, 0, 0, 9);     st_tab[8]  = 4'h0;  // IFNZ taken
    ins_tab[9]  = mk(31, 3, 3, 'hFF);  st_tab[9]  = 4'hF;  // reserved 1F
    ins_tab[10] = mk(21, 0, 0, 2);     st_tab[10] = 4'h1;  // IFGT not taken (C)
    ins_tab[11] = mk(20, 0, 0, 2);     st_tab[11] = 4'h1;  // IFST taken
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, ins_tab[i], st_tab[i]);
      exp_o = model(ins_tab[i], st_tab[i]); got = observed();
      checks++;
      if (got !== exp_o) begin
        errors++;
        $display("FAIL directed[%0d]: got %h expected %h", i, got, exp_o);
      end
      $display("directed[%0d]: ins=%h st=%h got=%h", i, ins_tab[i], st_tab[i], got);
    end
  endtask

  task automatic test_random();
    logic [15:0] ins;
    logic [3:0]  st;
    out_t exp_o, got;
    for (int i = 0; i < 300; i++) begin
      ins = 16'($urandom);
      st  = 4'($urandom);
      drive(1'b0, ins, st);
      exp_o = model(ins, st); got = observed();
      checks++;
      if (got !== exp_o) begin
        errors++;
        $display("FAIL random[%0d]: ins=%h st=%h got %h expected %h", i, ins, st, got, exp_o);
      end
      $display("random[%0d]: ins=%h st=%h got=%h", i, ins, st, got);
    end
  endtask

  // Reset asserted at random points in a running instruction stream.
  task automatic test_back_to_back();
    logic [15:0] ins;
    logic [3:0]  st;
    logic        r;
    out_t exp_o, got;
    for (int i = 0; i < 200; i++) begin
      ins = mk($urandom_range(0, 31), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 255));
      ins[10] = 1'($urandom); ins[2:0] = 3'($urandom);
      st  = 4'($urandom);
      r   = ($urandom_range(0, 9) == 0);
      drive(r, ins, st);
      exp_o = r ? reset_model() : model(ins, st);
      got = observed();
      checks++;
      if (got !== exp_o) begin
        errors++;
        $display("FAIL b2b[%0d]: rst=%0b ins=%h st=%h got %h expected %h", i, r, ins, st, got, exp_o);
      end
      $display("b2b[%0d]: rst=%0b ins=%h st=%h got=%h", i, r, ins, st, got);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
